// File: rtl/state_selector_pkg.sv
// Shared types and helpers for the button-driven state selector.
package state_sel_pkg;

    typedef logic [7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

    // Step up with wrap from max back to zero.
    function automatic state_t wrap_inc(input state_t cur, input state_t max);
        return (cur == max) ? 8'h00 : cur + 8'd1;
    endfunction

    // Step down with wrap from zero up to max.
    function automatic state_t wrap_dec(input state_t cur, input state_t max);
        return (cur == 8'h00) ? max : cur - 8'd1;
    endfunction

    // Largest of three cycle counts; sizes the shared wait counters.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/state_selector_button_debouncer.sv
// Synchronizer + debounce FSM for one raw button, emitting a one-cycle press_evt.
// Auto-repeat while held is built only when STATE_SEL_AUTO_REPEAT_EN is defined.
module button_debouncer
    import state_sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_ff;
    logic             sync;
    debounce_state_t  db_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign sync    = sync_ff[1];
    assign cnt_inc = cnt + CNT_W'(1);

`ifdef STATE_SEL_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_TARGET = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_TARGET = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_inc;
    logic             repeating;

    assign hold_inc = hold + CNT_W'(1);
`endif

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], btn};
        end
    end

    // Debounce FSM; the cycle that enters a wait counts as its first stable cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_state  <= IDLE;
            cnt       <= '0;
            press_evt <= 1'b0;
`ifdef STATE_SEL_AUTO_REPEAT_EN
            hold      <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            press_evt <= 1'b0;
            case (db_state)
                IDLE: begin
                    if (sync) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            db_state  <= PRESSED;
                            press_evt <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            db_state <= PRESS_WAIT;
                            cnt      <= CNT_W'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        db_state <= IDLE;
                        cnt      <= '0;
                    end else if (cnt_inc == DB_TARGET) begin
                        db_state  <= PRESSED;
                        press_evt <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        db_state <= (DEBOUNCE_CYCLES <= 1) ? IDLE : RELEASE_WAIT;
                        cnt      <= (DEBOUNCE_CYCLES <= 1) ? '0 : CNT_W'(1);
`ifdef STATE_SEL_AUTO_REPEAT_EN
                        hold      <= '0;
                        repeating <= 1'b0;
                    end else if (hold_inc == (repeating ? RP_TARGET : RD_TARGET)) begin
                        press_evt <= 1'b1;
                        hold      <= '0;
                        repeating <= 1'b1;
                    end else begin
                        hold <= hold_inc;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        db_state <= PRESSED;
                        cnt      <= '0;
                    end else if (cnt_inc == DB_TARGET) begin
                        db_state <= IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    db_state <= IDLE;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/state_selector.sv
// Debounced up/down buttons stepping a wrapping state register with a change strobe.
// Define STATE_SEL_AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module state_selector
    import state_sel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter state_t      STATE_MAX       = 8'hFF,
    parameter state_t      STATE_RESET     = 8'h00,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] state,
    output logic       state_change
);

    logic up_evt;
    logic down_evt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_up (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_up),
        .press_evt(up_evt)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_down (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn_down),
        .press_evt(down_evt)
    );

    // Simultaneous up and down events cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= STATE_RESET;
            state_change <= 1'b0;
        end else begin
            state_change <= 1'b0;
            if (up_evt && !down_evt) begin
                state        <= wrap_inc(state, STATE_MAX);
                state_change <= 1'b1;
            end else if (down_evt && !up_evt) begin
                state        <= wrap_dec(state, STATE_MAX);
                state_change <= 1'b1;
            end
        end
    end

endmodule
